mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 99 +++++++++
 tb/tb_mem_port_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Two-requester arbiter for one shared memory port with a fixed
//            LATENCY-cycle hold per grant. ARB_FIXED_PRIORITY_EN selects
//            fixed priority (requester 0 wins ties) instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] addr1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             sel,
    output logic             mem_en,
    output logic [WIDTH-1:0] mem_addr
);

    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_BUSY     = 1'b1;
    localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);
    // With a single-cycle hold the first grant cycle is also the last one.
    localparam logic       c_LAST     = (LATENCY == 1);

    logic [0:0] r_state;
    logic [3:0] r_cnt;
    logic       w_win1;

`ifdef ARB_FIXED_PRIORITY_EN
    assign w_win1 = req1 & ~req0;
`else
    logic r_last_owner;
    // On a tie, requester 1 wins only if requester 0 took the previous grant.
    assign w_win1 = req1 & (~req0 | ~r_last_owner);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= 4'd0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            sel      <= 1'b0;
            mem_en   <= 1'b0;
            mem_addr <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
            r_last_owner <= 1'b1;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req0 | req1) begin
                        r_state  <= c_BUSY;
                        r_cnt    <= c_CNT_LOAD;
                        sel      <= w_win1;
                        gnt0     <= ~w_win1;
                        gnt1     <= w_win1;
                        mem_en   <= 1'b1;
                        mem_addr <= w_win1 ? addr1 : addr0;
                        done0    <= c_LAST & ~w_win1;
                        done1    <= c_LAST & w_win1;
`ifndef ARB_FIXED_PRIORITY_EN
                        r_last_owner <= w_win1;
`endif
                    end
                end
                default: begin
                    // Outputs are registered, so done is raised one edge early
                    // to land on the final grant cycle.
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                        done0 <= (r_cnt == 4'd1) & ~sel;
                        done1 <= (r_cnt == 4'd1) & sel;
                    end else begin
                        r_state <= c_IDLE;
                        gnt0    <= 1'b0;
                        gnt1    <= 1'b0;
                        mem_en  <= 1'b0;
                        done0   <= 1'b0;
                        done1   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed bench for mem_port_arbiter at LATENCY 1, 2 and 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

`ifdef ARB_FIXED_PRIORITY_EN
    localparam bit c_FIXED = 1'b1;
`else
    localparam bit c_FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [31:0] addr0, addr1;

    // Index i holds the instance built with LATENCY = i+1.
    logic        gnt0 [3];
    logic        gnt1 [3];
    logic        done0 [3];
    logic        done1 [3];
    logic        sel [3];
    logic        mem_en [3];
    logic [31:0] mem_addr [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        mem_port_arbiter #(.WIDTH(32), .LATENCY(i + 1)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .req0     (req0),
            .req1     (req1),
            .addr0    (addr0),
            .addr1    (addr1),
            .gnt0     (gnt0[i]),
            .gnt1     (gnt1[i]),
            .done0    (done0[i]),
            .done1    (done1[i]),
            .sel      (sel[i]),
            .mem_en   (mem_en[i]),
            .mem_addr (mem_addr[i])
        );
    end

    // {gnt0, gnt1, done0, done1, mem_en}
    function automatic logic [4:0] st(input int i);
        return {gnt0[i], gnt1[i], done0[i], done1[i], mem_en[i]};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic       own;
        logic [4:0] e5;

        addr0 = 32'h0;
        addr1 = 32'h0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_st%0d", i), st(i), 5'b00000);
            check($sformatf("rst_sel%0d", i), sel[i], 1'b0);
            check($sformatf("rst_addr%0d", i), mem_addr[i], 32'h0);
        end

        // Single requester 0, LATENCY 2
        req0 = 1'b1; addr0 = 32'h100;
        tick();
        req0 = 1'b0;
        check("single_c1_st", st(1), 5'b10001);
        check("single_c1_sel", sel[1], 1'b0);
        check("single_c1_addr", mem_addr[1], 32'h100);
        tick();
        check("single_c2_st", st(1), 5'b10101);
        check("single_c2_addr", mem_addr[1], 32'h100);
        tick();
        check("single_c3_idle", st(1), 5'b00000);

        // Both requests held from reset: alternation at LATENCY 2 and 1
        do_reset();
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'hA; addr1 = 32'hB;
        for (int k = 0; k < 12; k++) begin
            tick();
            own = c_FIXED ? 1'b0 : 1'((k / 3) % 2);
            if (k % 3 == 2) e5 = 5'b00000;
            else e5 = {~own, own, (k % 3 == 1) & ~own, (k % 3 == 1) & own, 1'b1};
            check($sformatf("tie_l2_st_k%0d", k), st(1), e5);
            if (k % 3 != 2) begin
                check($sformatf("tie_l2_sel_k%0d", k), sel[1], own);
                check($sformatf("tie_l2_addr_k%0d", k), mem_addr[1], own ? 32'hB : 32'hA);
            end
            own = c_FIXED ? 1'b0 : 1'((k / 2) % 2);
            if (k % 2 == 1) e5 = 5'b00000;
            else e5 = {~own, own, ~own, own, 1'b1};
            check($sformatf("tie_l1_st_k%0d", k), st(0), e5);
            if (k % 2 == 0)
                check($sformatf("tie_l1_addr_k%0d", k), mem_addr[0], own ? 32'hB : 32'hA);
        end

        // req1 pulsed, then its address changes mid-grant
        do_reset();
        req1 = 1'b1; addr1 = 32'h55;
        tick();
        req1 = 1'b0; addr1 = 32'h77;
        check("pulse_c1_st", st(1), 5'b01001);
        check("pulse_c1_sel", sel[1], 1'b1);
        check("pulse_c1_addr", mem_addr[1], 32'h55);
        tick();
        check("pulse_c2_st", st(1), 5'b01011);
        check("pulse_c2_addr", mem_addr[1], 32'h55);
        tick();
        check("pulse_c3_idle", st(1), 5'b00000);

        // Reset in the first busy cycle at LATENCY 3
        do_reset();
        req0 = 1'b1; addr0 = 32'h33;
        tick();
        check("abort_c1_st", st(2), 5'b10001);
        check("abort_c1_addr", mem_addr[2], 32'h33);
        rst = 1'b1; req0 = 1'b0;
        #1;
        check("abort_async_st", st(2), 5'b00000);
        check("abort_async_sel", sel[2], 1'b0);
        check("abort_async_addr", mem_addr[2], 32'h0);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("abort_quiet_k%0d", k), st(2), 5'b00000);
        end
        req0 = 1'b1; addr0 = 32'h44;
        tick();
        req0 = 1'b0;
        check("regrant_c1_st", st(2), 5'b10001);
        check("regrant_c1_addr", mem_addr[2], 32'h44);
        tick();
        check("regrant_c2_st", st(2), 5'b10001);
        tick();
        check("regrant_c3_st", st(2), 5'b10101);
        tick();
        check("regrant_c4_idle", st(2), 5'b00000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
